// File: rtl/quad_pkg.sv
// Shared types and Gray-step decode for the quadrature decoder.
// Imported by quad_sync and quad_step_decoder.
package quad_pkg;

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ILLEGAL
  } step_t;

  // {prev, s}: forward is 00->01->11->10->00, reverse the opposite way
  function automatic step_t decode(
    input logic [1:0] prev,
    input logic [1:0] s
  );
    step_t r;
    unique case ({prev, s})
      4'b0001, 4'b0111,
      4'b1110, 4'b1000: r = STEP_FWD;
      4'b0010, 4'b1011,
      4'b1101, 4'b0100: r = STEP_REV;
      4'b0011, 4'b1100,
      4'b0110, 4'b1001: r = STEP_ILLEGAL;
      default:          r = STEP_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_sync.sv
// Multi-flop synchronizer for one raw encoder pin.
// STAGES must be at least 2.
module quad_sync
  import quad_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/quad_step_decoder.sv
// x4 quadrature decoder: synchronized phases -> up/down strobes + count.
// Optional glitch filter: define QUAD_GLITCH_FILTER_EN.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             phase_a,
  input  logic             phase_b,
  input  logic             enable,
  input  logic             clr_err,
  output logic             up,
  output logic             down,
  output logic [WIDTH-1:0] count,
  output logic             err,
  output logic             err_sticky
);

  localparam int CW = $clog2(SYNC_STAGES + 1) + 1;

  logic          a_sync;
  logic          b_sync;
  logic [1:0]    s;
  logic [1:0]    prev;
  logic [1:0]    prev_nx;
  logic          s_ok;
  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] init_cnt;
  step_t         step;
  logic          up_nx;
  logic          down_nx;
  logic          err_nx;

  quad_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .d     (phase_a),
    .q     (a_sync)
  );

  quad_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d     (phase_b),
    .q     (b_sync)
  );

  assign s = {a_sync, b_sync};

`ifdef QUAD_GLITCH_FILTER_EN
  logic [1:0] filt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= 2'b00;
    end else begin
      filt <= s;
    end
  end

  assign s_ok = (s == filt);
`else
  assign s_ok = 1'b1;
`endif

  // INIT lingers until the synchronizers hold real pin values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) begin
        init_cnt <= init_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT: begin
        if (init_cnt == CW'(SYNC_STAGES)) begin
          state_nx = TRACK;
        end
      end
      TRACK:   state_nx = TRACK;
      default: state_nx = INIT;
    endcase
  end

  always_comb begin
    step    = STEP_NONE;
    prev_nx = prev;
    unique case (state)
      INIT: prev_nx = s;
      TRACK: begin
        if (s_ok) begin
          step    = decode(prev, s);
          prev_nx = s;
        end
      end
      default: prev_nx = s;
    endcase
    up_nx   = enable && (step == STEP_FWD);
    down_nx = enable && (step == STEP_REV);
    err_nx  = (step == STEP_ILLEGAL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev       <= 2'b00;
      up         <= 1'b0;
      down       <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      count      <= '0;
    end else begin
      prev <= prev_nx;
      up   <= up_nx;
      down <= down_nx;
      err  <= err_nx;
      if (err_nx) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
      if (up_nx) begin
        count <= count + WIDTH'(1);
      end else if (down_nx) begin
        count <= count - WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: vector table,
// directed corner sequences and random phases vs. a position model.
module tb_quad_step_decoder;

  localparam int WIDTH = 4;
  localparam int SS    = 2;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             phase_a = 1'b0;
  logic             phase_b = 1'b0;
  logic             enable = 1'b1;
  logic             clr_err = 1'b0;
  logic             up;
  logic             down;
  logic [WIDTH-1:0] count;
  logic             err;
  logic             err_sticky;

  quad_step_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .reset      (reset),
    .phase_a    (phase_a),
    .phase_b    (phase_b),
    .enable     (enable),
    .clr_err    (clr_err),
    .up         (up),
    .down       (down),
    .count      (count),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: raw pin history since reset release, position in quadrature
  logic [1:0]       hist[$];
  int               m;
  logic [1:0]       mprev;
  logic [WIDTH-1:0] mcount;
  logic             msticky;
  int               n_up, n_down, n_err;

  typedef struct {
    logic [1:0]       ph;
    logic             en;
    logic [WIDTH-1:0] exp_count;
    logic             exp_sticky;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pos(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic set_ph(input logic [1:0] p);
    phase_a = p[1];
    phase_b = p[0];
  endtask

  // one clock edge: predict, wait, compare
  task automatic tick();
    logic [1:0] s, f;
    logic eu, ed, ee;
    int d;
    hist.push_back({phase_a, phase_b});
    m++;
    s  = (m >= SS + 1) ? hist[m-1-SS] : 2'b00;
    f  = (m >= SS + 2) ? hist[m-2-SS] : 2'b00;
    eu = 1'b0;
    ed = 1'b0;
    ee = 1'b0;
    if (m <= SS + 1) begin
      mprev = s;
    end else if (!FILT || s == f) begin
      d     = (pos(s) - pos(mprev)) & 3;
      ee    = (d == 2);
      eu    = enable && (d == 1);
      ed    = enable && (d == 3);
      mprev = s;
    end
    if (eu) mcount = mcount + WIDTH'(1);
    if (ed) mcount = mcount - WIDTH'(1);
    if (ee) msticky = 1'b1;
    else if (clr_err) msticky = 1'b0;
    @(posedge clk);
    #1;
    n_up   += int'(up);
    n_down += int'(down);
    n_err  += int'(err);
    chk("up", int'(up), int'(eu));
    chk("down", int'(down), int'(ed));
    chk("err", int'(err), int'(ee));
    chk("count", int'(count), int'(mcount));
    chk("err_sticky", int'(err_sticky), int'(msticky));
    chk("up_and_down", int'(up & down), 0);
  endtask

  task automatic hold(input logic [1:0] p, input int n);
    set_ph(p);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input logic [1:0] p);
    reset = 1'b1;
    set_ph(p);
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_pulses", int'(up | down | err | err_sticky), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    enable  = 1'b1;
    clr_err = 1'b0;
    hist.delete();
    m       = 0;
    mprev   = 2'b00;
    mcount  = '0;
    msticky = 1'b0;
    n_up    = 0;
    n_down  = 0;
    n_err   = 0;
  endtask

  initial begin
    int lat;
    logic [1:0] ph;

    vecs[0]  = '{2'b00, 1'b1, 4'h0, 1'b0};
    vecs[1]  = '{2'b01, 1'b1, 4'h1, 1'b0};
    vecs[2]  = '{2'b11, 1'b1, 4'h2, 1'b0};
    vecs[3]  = '{2'b10, 1'b1, 4'h3, 1'b0};
    vecs[4]  = '{2'b00, 1'b1, 4'h4, 1'b0};
    vecs[5]  = '{2'b10, 1'b1, 4'h3, 1'b0};
    vecs[6]  = '{2'b11, 1'b1, 4'h2, 1'b0};
    vecs[7]  = '{2'b01, 1'b1, 4'h1, 1'b0};
    vecs[8]  = '{2'b00, 1'b1, 4'h0, 1'b0};
    vecs[9]  = '{2'b10, 1'b1, 4'hF, 1'b0};
    vecs[10] = '{2'b11, 1'b1, 4'hE, 1'b0};
    vecs[11] = '{2'b01, 1'b1, 4'hD, 1'b0};
    vecs[12] = '{2'b10, 1'b1, 4'hD, 1'b1};
    vecs[13] = '{2'b11, 1'b1, 4'hC, 1'b1};
    vecs[14] = '{2'b10, 1'b0, 4'hC, 1'b1};
    vecs[15] = '{2'b00, 1'b1, 4'hD, 1'b1};

    #2;
    // table of held phase positions
    do_reset(2'b00);
    for (int i = 0; i < 16; i++) begin
      enable = vecs[i].en;
      hold(vecs[i].ph, 6);
      chk($sformatf("vec%0d_count", i), int'(count),
          int'(vecs[i].exp_count));
      chk($sformatf("vec%0d_sticky", i), int'(err_sticky),
          int'(vecs[i].exp_sticky));
    end
    enable = 1'b1;

    // encoder resting at 11 across reset release
    do_reset(2'b11);
    hold(2'b11, 10);
    chk("rest11_count", int'(count), 0);
    chk("rest11_pulses", n_up + n_down + n_err, 0);

    // 5 forward cycles of 4 steps
    do_reset(2'b00);
    for (int r = 0; r < 5; r++) begin
      hold(2'b00, 4);
      hold(2'b01, 4);
      hold(2'b11, 4);
      hold(2'b10, 4);
      hold(2'b00, 4);
    end
    hold(2'b00, 4);
    chk("fwd_ups", n_up, 20);
    chk("fwd_downs", n_down, 0);
    chk("fwd_count", int'(count), 4);

    // single reverse step latency and wrap to F
    do_reset(2'b00);
    hold(2'b00, 6);
    set_ph(2'b10);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      tick();
      if (down) lat = i;
    end
    chk("rev_latency", lat, SS + 1 + int'(FILT));
    chk("rev_count", int'(count), 15);
    hold(2'b10, 4);
    chk("rev_downs", n_down, 1);

    // illegal jump, clear, then legal step
    do_reset(2'b00);
    hold(2'b00, 6);
    hold(2'b11, 5);
    chk("ill_errs", n_err, 1);
    chk("ill_sticky", int'(err_sticky), 1);
    chk("ill_count", int'(count), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_sticky", int'(err_sticky), 0);
    hold(2'b10, 5);
    chk("post_ill_ups", n_up, 1);
    chk("post_ill_count", int'(count), 1);

    // steps while disabled are lost
    do_reset(2'b00);
    hold(2'b00, 6);
    enable = 1'b0;
    hold(2'b01, 4);
    hold(2'b11, 4);
    hold(2'b10, 4);
    hold(2'b00, 4);
    enable = 1'b1;
    hold(2'b01, 5);
    chk("en_count", int'(count), 1);
    chk("en_ups", n_up, 1);

    // async reset at count 7
    do_reset(2'b00);
    hold(2'b00, 6);
    for (int i = 0; i < 7; i++) begin
      ph = 2'((i + 1) & 3);
      hold((ph == 2'd2) ? 2'b11 : (ph == 2'd3) ? 2'b10 : ph, 4);
    end
    chk("pre_rst_count", int'(count), 7);
    do_reset(2'b00);

`ifdef QUAD_GLITCH_FILTER_EN
    hold(2'b00, 6);
    hold(2'b01, 1);
    hold(2'b00, 6);
    chk("glitch_pulses", n_up + n_down + n_err, 0);
    chk("glitch_count", int'(count), 0);
`endif

    // random phases vs. model
    do_reset(2'b00);
    for (int i = 0; i < 300; i++) begin
      enable = ($urandom % 8) != 0;
      set_ph(2'($urandom % 4));
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        clr_err = ($urandom % 6) == 0;
        tick();
      end
    end
    clr_err = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
